// File: rtl/ps2_cpc_pkg.sv
// Shared constants, receiver state type and the PS/2 set-2 to CPC matrix lookup.
// The table maps {extended, code} to a matrix index (row*8+col) or NO_KEY.
package ps2_cpc_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam int         MATRIX_W  = 80;
    localparam logic [6:0] NO_KEY    = 7'h7F;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    function automatic logic [6:0] scan_to_cpc(input logic ext, input logic [7:0] code);
        logic [6:0] idx;
        idx = NO_KEY;
        if (ext) begin
            case (code)
                8'h75: idx = 7'd0;   8'h74: idx = 7'd1;   8'h72: idx = 7'd2;
                8'h5A: idx = 7'd6;   8'h6B: idx = 7'd8;   8'h71: idx = 7'd16;
                8'h14: idx = 7'd23;
                default: idx = NO_KEY;
            endcase
        end else begin
            case (code)
                8'h05: idx = 7'd13;  8'h06: idx = 7'd14;  8'h11: idx = 7'd9;
                8'h54: idx = 7'd17;  8'h5A: idx = 7'd18;  8'h5B: idx = 7'd19;
                8'h12: idx = 7'd21;  8'h59: idx = 7'd21;  8'h5D: idx = 7'd22;
                8'h14: idx = 7'd23;  8'h55: idx = 7'd24;  8'h4E: idx = 7'd25;
                8'h4D: idx = 7'd27;  8'h4C: idx = 7'd28;  8'h52: idx = 7'd29;
                8'h4A: idx = 7'd30;  8'h49: idx = 7'd31;  8'h45: idx = 7'd32;
                8'h46: idx = 7'd33;  8'h44: idx = 7'd34;  8'h43: idx = 7'd35;
                8'h4B: idx = 7'd36;  8'h42: idx = 7'd37;  8'h3A: idx = 7'd38;
                8'h41: idx = 7'd39;  8'h3E: idx = 7'd40;  8'h3D: idx = 7'd41;
                8'h3C: idx = 7'd42;  8'h35: idx = 7'd43;  8'h33: idx = 7'd44;
                8'h3B: idx = 7'd45;  8'h31: idx = 7'd46;  8'h29: idx = 7'd47;
                8'h36: idx = 7'd48;  8'h2E: idx = 7'd49;  8'h2D: idx = 7'd50;
                8'h2C: idx = 7'd51;  8'h34: idx = 7'd52;  8'h2B: idx = 7'd53;
                8'h32: idx = 7'd54;  8'h2A: idx = 7'd55;  8'h25: idx = 7'd56;
                8'h26: idx = 7'd57;  8'h24: idx = 7'd58;  8'h1D: idx = 7'd59;
                8'h1B: idx = 7'd60;  8'h23: idx = 7'd61;  8'h21: idx = 7'd62;
                8'h22: idx = 7'd63;  8'h16: idx = 7'd64;  8'h1E: idx = 7'd65;
                8'h76: idx = 7'd66;  8'h15: idx = 7'd67;  8'h0D: idx = 7'd68;
                8'h1C: idx = 7'd69;  8'h58: idx = 7'd70;  8'h1A: idx = 7'd71;
                8'h66: idx = 7'd79;
                default: idx = NO_KEY;
            endcase
        end
        return idx;
    endfunction

endpackage

// File: rtl/ps2_cpc_matrix_if.sv
// PS/2 pin inputs and CPC matrix / event outputs of the keyboard block.
// slave is the matrix block's view, master the driving/observing side.
interface ps2_cpc_matrix_if;
    import ps2_cpc_pkg::*;

    logic                ps2_clk_i;
    logic                ps2_data_i;
    logic [MATRIX_W-1:0] keyboard_o;
    logic                key_event_o;
    logic [6:0]          key_index_o;
    logic                key_make_o;
    logic                frame_err_o;

    modport slave  (input  ps2_clk_i, ps2_data_i,
                    output keyboard_o, key_event_o, key_index_o, key_make_o, frame_err_o);
    modport master (output ps2_clk_i, ps2_data_i,
                    input  keyboard_o, key_event_o, key_index_o, key_make_o, frame_err_o);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: 2-FF sync, ps2_clk glitch filter, 11-bit frame FSM, mid-frame timeout.
// valid_o/err_o are single-cycle pulses the cycle after the stop-bit falling edge; no backpressure.
module ps2_rx
    import ps2_cpc_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 16000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       err_o
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_s_q, dat_s_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    rx_state_e     state_q;
    logic [2:0]    bit_q;
    logic [7:0]    sr_q, data_q;
    logic          par_q, valid_q, err_q;
    logic [TW-1:0] tmo_q;
    logic          accept, fall, din;

    assign din    = dat_s_q[1];
    // A new level is taken only after FILTER_LEN consecutive differing samples.
    assign accept = (clk_s_q[1] != filt_q) && (fcnt_q == FW'(FILTER_LEN - 1));
    assign fall   = accept && filt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            clk_s_q <= 2'b11;
            dat_s_q <= 2'b11;
            filt_q  <= 1'b1;
            fcnt_q  <= '0;
            state_q <= RX_IDLE;
            bit_q   <= '0;
            sr_q    <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            clk_s_q <= {clk_s_q[0], ps2_clk_i};
            dat_s_q <= {dat_s_q[0], ps2_data_i};
            valid_q <= 1'b0;
            err_q   <= 1'b0;

            if (clk_s_q[1] == filt_q) begin
                fcnt_q <= '0;
            end else if (accept) begin
                filt_q <= clk_s_q[1];
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + 1'b1;
            end

            if (state_q == RX_IDLE || fall) tmo_q <= '0;
            else                            tmo_q <= tmo_q + 1'b1;

            if (state_q != RX_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_q <= RX_IDLE;
                err_q   <= 1'b1;
            end else if (fall) begin
                case (state_q)
                    RX_IDLE: begin
                        // A high start bit is line noise, not a frame.
                        if (!din) begin
                            state_q <= RX_DATA;
                            bit_q   <= '0;
                        end
                    end
                    RX_DATA: begin
                        sr_q  <= {din, sr_q[7:1]};
                        bit_q <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par_q   <= ^{din, sr_q};
                        state_q <= RX_STOP;
                    end
                    RX_STOP: begin
                        state_q <= RX_IDLE;
                        if (din && par_q) begin
                            valid_q <= 1'b1;
                            data_q  <= sr_q;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
endmodule

// File: rtl/ps2_cpc_matrix.sv
// PS/2 keyboard to CPC active-low 10x8 matrix: prefix decode, key lookup, matrix register.
// Matrix and event outputs update one cycle after a received byte; no backpressure.
module ps2_cpc_matrix
    import ps2_cpc_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 16000
) (
    input  logic            clk_i,
    input  logic            reset_i,
    ps2_cpc_matrix_if.slave bus
);
    logic [7:0]          rx_data;
    logic                rx_vld, rx_err;
    logic [MATRIX_W-1:0] kbd_q;
    logic                event_q, make_q, ext_q, brk_q;
    logic [6:0]          index_q, idx_w;
    logic [2:0]          skip_q;

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .ps2_clk_i  (bus.ps2_clk_i),
        .ps2_data_i (bus.ps2_data_i),
        .data_o     (rx_data),
        .valid_o    (rx_vld),
        .err_o      (rx_err)
    );

    assign idx_w = scan_to_cpc(ext_q, rx_data);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            kbd_q   <= '1;
            event_q <= 1'b0;
            index_q <= '0;
            make_q  <= 1'b0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            skip_q  <= '0;
        end else begin
            event_q <= 1'b0;
            if (rx_err) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (rx_vld) begin
                // Pause sends E1 plus seven bytes that carry no key state.
                if (skip_q != 3'd0) begin
                    skip_q <= skip_q - 1'b1;
                end else begin
                    case (rx_data)
                        PS2_EXT:   ext_q  <= 1'b1;
                        PS2_BRK:   brk_q  <= 1'b1;
                        PS2_PAUSE: skip_q <= 3'd7;
                        PS2_BAT, 8'hFC, 8'h00, 8'hFF: begin
                            kbd_q <= '1;
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                        end
                        default: begin
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                            if (idx_w != NO_KEY) begin
                                kbd_q[idx_w] <= brk_q;
                                event_q      <= 1'b1;
                                index_q      <= idx_w;
                                make_q       <= ~brk_q;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign bus.keyboard_o  = kbd_q;
    assign bus.key_event_o = event_q;
    assign bus.key_index_o = index_q;
    assign bus.key_make_o  = make_q;
    assign bus.frame_err_o = rx_err;
endmodule
